// File: rtl/gift_pkg.sv
// Shared types and constants for the GIFT-128 streaming encryption controller.
package gift_pkg;

  localparam int GIFT_BLK_W = 128;
  localparam int GIFT_KEY_W = 128;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_KEY_LD   = 3'd1,
    ST_KEY_WAIT = 3'd2,
    ST_READY    = 3'd3,
    ST_START    = 3'd4,
    ST_ENC_WAIT = 3'd5
  } state_t;

  // States in which the controller has key or block work outstanding.
  function automatic logic in_flight(state_t st);
    return st inside {ST_KEY_LD, ST_KEY_WAIT, ST_START, ST_ENC_WAIT};
  endfunction

endpackage

// File: rtl/gift_enc_stream_controller_if.sv
// Key, plaintext and ciphertext stream ports of the GIFT-128 stream controller.
interface gift_enc_stream_controller_if #(
  parameter int BLK_W = gift_pkg::GIFT_BLK_W,
  parameter int KEY_W = gift_pkg::GIFT_KEY_W
);
  logic             key_valid_i;
  logic [KEY_W-1:0] key_i;
  logic             key_ready_o;
  logic             data_valid_i;
  logic [BLK_W-1:0] data_i;
  logic             data_ready_o;
  logic             cipher_valid_o;
  logic [BLK_W-1:0] cipher_o;
  logic             cipher_ready_i;

  // Stream source/sink side
  modport master (
    output key_valid_i, key_i, data_valid_i, data_i, cipher_ready_i,
    input  key_ready_o, data_ready_o, cipher_valid_o, cipher_o
  );

  // Controller side
  modport slave (
    input  key_valid_i, key_i, data_valid_i, data_i, cipher_ready_i,
    output key_ready_o, data_ready_o, cipher_valid_o, cipher_o
  );
endinterface

// File: rtl/gift_ctrl_fifo.sv
// Plaintext FIFO: pointers carry one extra wrap bit to tell full from empty.
module gift_ctrl_fifo #(
  parameter int W     = 128,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         wr_en, rd_en;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en   = pop && !empty;
  // a pop in the same cycle frees the slot, so push on full is legal then
  assign wr_en   = push && (!full || rd_en);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // Read/write pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/gift_enc_stream_controller.sv
// Streaming GIFT-128 controller: caches the key, queues plaintexts and feeds
// one gift_128_enc core back-to-back, returning ciphertext with backpressure.
module gift_enc_stream_controller
  import gift_pkg::*;
#(
  parameter int BLK_W = GIFT_BLK_W,
  parameter int KEY_W = GIFT_KEY_W,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_n,
  gift_enc_stream_controller_if.slave s,
  output logic [KEY_W-1:0]     core_key_o,
  output logic                 core_key_ld_o,
  input  logic                 core_key_done_i,
  output logic [BLK_W-1:0]     core_data_o,
  output logic                 core_start_o,
  input  logic [BLK_W-1:0]     core_cipher_i,
  input  logic                 core_done_i,
  output logic                 busy_o,
  output logic [CNT_W-1:0]     blk_cnt_o
);
  state_t           state;
  logic             key_loaded;
  logic             kw_first;
  logic             live;
  logic             cipher_vld;
  logic [BLK_W-1:0] cipher_q;
  logic [CNT_W-1:0] blk_cnt;
  logic             fifo_full, fifo_empty;
  logic [BLK_W-1:0] fifo_head;
  logic             key_hs, data_hs, cipher_hs, slot_free, pop, capture;

  // live is low in reset and for the first edge after it, which keeps
  // key_ready at 0 while reset is asserted like every other output. A key is
  // only taken with nothing queued or pending so it never applies to old data.
  assign s.key_ready_o    = live && (state == ST_IDLE || state == ST_READY)
                            && fifo_empty && !cipher_vld;
  assign s.data_ready_o   = key_loaded && !fifo_full && !s.key_valid_i;
  assign s.cipher_valid_o = cipher_vld;
  assign s.cipher_o       = cipher_q;

  assign key_hs    = s.key_valid_i && s.key_ready_o;
  assign data_hs   = s.data_valid_i && s.data_ready_o;
  assign cipher_hs = cipher_vld && s.cipher_ready_i;
  // only start a block if its result will have somewhere to land
  assign slot_free = !cipher_vld || s.cipher_ready_i;
  assign pop       = (state == ST_READY) && !key_hs && !fifo_empty && slot_free;
  assign capture   = (state == ST_ENC_WAIT) && core_done_i;
  assign busy_o    = !fifo_empty || in_flight(state);
  assign blk_cnt_o = blk_cnt;

  gift_ctrl_fifo #(.W(BLK_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk_i),
    .rst_n   (reset_n),
    .push    (data_hs),
    .pop     (pop),
    .wr_data (s.data_i),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Control FSM with registered core-side outputs and start pulses
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      key_loaded    <= 1'b0;
      kw_first      <= 1'b0;
      live          <= 1'b0;
      core_key_o    <= '0;
      core_key_ld_o <= 1'b0;
      core_data_o   <= '0;
      core_start_o  <= 1'b0;
    end else begin
      live          <= 1'b1;
      core_key_ld_o <= 1'b0;
      core_start_o  <= 1'b0;
      unique case (state)
        ST_IDLE, ST_READY: begin
          if (key_hs) begin
            core_key_o    <= s.key_i;
            key_loaded    <= 1'b0;
            core_key_ld_o <= 1'b1;
            state         <= ST_KEY_LD;
          end else if (pop) begin
            core_data_o  <= fifo_head;
            core_start_o <= 1'b1;
            state        <= ST_START;
          end
        end
        ST_KEY_LD: begin
          kw_first <= 1'b1;
          state    <= ST_KEY_WAIT;
        end
        ST_KEY_WAIT: begin
          // the core's done latch may still show the previous key for a cycle
          if (kw_first) begin
            kw_first <= 1'b0;
          end else if (core_key_done_i) begin
            key_loaded <= 1'b1;
            state      <= ST_READY;
          end
        end
        ST_START:    state <= ST_ENC_WAIT;
        ST_ENC_WAIT: if (core_done_i) state <= ST_READY;
        default:     state <= ST_IDLE;
      endcase
    end
  end

  // Ciphertext output slot and delivered-block counter
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      cipher_vld <= 1'b0;
      cipher_q   <= '0;
      blk_cnt    <= '0;
    end else begin
      if (capture) begin
        cipher_q   <= core_cipher_i;
        cipher_vld <= 1'b1;
      end else if (cipher_hs) begin
        cipher_vld <= 1'b0;
      end
      if (cipher_hs) blk_cnt <= blk_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_gift_enc_stream_controller.sv
// Bench for gift_enc_stream_controller: behavioural core stand-in, queue-based
// scoreboard, a vector table and hand-written multi-cycle sequences.
module tb_gift_enc_stream_controller;
  localparam int BW = 128;
  localparam int KW = 128;
  localparam int CW = 16;
  localparam logic [127:0] GOLD = 128'hcd0bd738388ad3f668b15a36ceb6ff92;
  localparam int KEY_LAT = 6;

  logic clk_i = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk_i = ~clk_i;

  gift_enc_stream_controller_if #(.BLK_W(BW), .KEY_W(KW)) bus ();

  logic [KW-1:0] core_key_o;
  logic          core_key_ld_o, core_key_done_i;
  logic [BW-1:0] core_data_o, core_cipher_i;
  logic          core_start_o, core_done_i, busy_o;
  logic [CW-1:0] blk_cnt_o;

  gift_enc_stream_controller #(.BLK_W(BW), .KEY_W(KW), .DEPTH(4), .CNT_W(CW)) dut (
    .clk_i           (clk_i),
    .reset_n         (reset_n),
    .s               (bus),
    .core_key_o      (core_key_o),
    .core_key_ld_o   (core_key_ld_o),
    .core_key_done_i (core_key_done_i),
    .core_data_o     (core_data_o),
    .core_start_o    (core_start_o),
    .core_cipher_i   (core_cipher_i),
    .core_done_i     (core_done_i),
    .busy_o          (busy_o),
    .blk_cnt_o       (blk_cnt_o)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Stand-in for the core's cipher: matches the published vector for key=0,pt=0
  // and differs for any other key or plaintext.
  function automatic logic [127:0] mock_enc(input logic [127:0] k, input logic [127:0] p);
    return GOLD ^ {p[63:0], p[127:64]} ^ {k[31:0], k[127:32]} ^ (k << 3);
  endfunction

  // ---------------- core model ----------------
  logic [127:0] m_key = '0, m_cipher = '0;
  logic m_kdone = 1'b0, m_done = 1'b0, kclr = 1'b0, stray = 1'b0;
  int kcnt = 0, ecnt = 0;
  assign core_key_done_i = m_kdone;
  assign core_done_i     = m_done | stray;
  assign core_cipher_i   = stray ? ~m_cipher : m_cipher;

  always @(posedge clk_i) begin
    m_done <= 1'b0;
    if (core_key_ld_o) begin
      m_key <= core_key_o;
      kcnt  <= KEY_LAT;
      kclr  <= 1'b1;           // done latch drops one cycle late
    end else begin
      if (kclr) begin m_kdone <= 1'b0; kclr <= 1'b0; end
      if (kcnt > 0) begin
        kcnt <= kcnt - 1;
        if (kcnt == 1) m_kdone <= 1'b1;
      end
    end
    if (core_start_o) begin
      m_cipher <= mock_enc(m_key, core_data_o);
      ecnt     <= int'($urandom_range(6, 1));
    end else if (ecnt > 0) begin
      ecnt <= ecnt - 1;
      if (ecnt == 1) m_done <= 1'b1;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [127:0] exp_q[$];
  logic [127:0] cur_key = '0, last_ct = '0;
  logic [15:0]  cnt_mdl = '0;
  int occ = 0, n_ld = 0, n_start = 0, n_deliv = 0;
  bit chk_dr = 1'b0;

  always @(negedge clk_i) begin
    if (reset_n) begin
      if (core_key_ld_o) n_ld++;
      if (core_start_o) begin n_start++; occ--; end
      if (chk_dr) check("data_ready_vs_fifo_fill", bus.data_ready_o, (occ != 4));
      if (bus.key_valid_i && bus.key_ready_o) cur_key = bus.key_i;
      if (bus.data_valid_i && bus.data_ready_o) begin
        exp_q.push_back(mock_enc(cur_key, bus.data_i));
        occ++;
      end
      if (bus.cipher_valid_o && bus.cipher_ready_i) begin
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL cipher_unexpected: got %h expected none", bus.cipher_o);
        end else begin
          check("cipher_order", bus.cipher_o, exp_q.pop_front());
        end
        check("blk_cnt_before_hs", blk_cnt_o, cnt_mdl);
        cnt_mdl++;
        n_deliv++;
        last_ct = bus.cipher_o;
      end
    end
  end

  // ---------------- tasks ----------------
  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctrl"}, {bus.key_ready_o, bus.data_ready_o, bus.cipher_valid_o,
                           core_key_ld_o, core_start_o, busy_o}, '0);
    check({tag, "_cipher"}, bus.cipher_o, '0);
    check({tag, "_core_key"}, core_key_o, '0);
    check({tag, "_core_data"}, core_data_o, '0);
    check({tag, "_blk_cnt"}, blk_cnt_o, '0);
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    bus.key_valid_i = 1'b0; bus.key_i = '0;
    bus.data_valid_i = 1'b0; bus.data_i = '0;
    bus.cipher_ready_i = 1'b0; stray = 1'b0;
    exp_q.delete(); occ = 0; cnt_mdl = '0;
    #1;
    check_zero(tag);
    repeat (2) @(posedge clk_i);
    #1 reset_n = 1'b1;
    tick();
  endtask

  task automatic load_key(input logic [127:0] k);
    bit ok = 1'b0;
    bus.key_valid_i = 1'b1; bus.key_i = k;
    for (int i = 0; i < 300 && !ok; i++) begin @(negedge clk_i); ok = bus.key_ready_o; end
    check("key_accept_timeout", ok, 1);
    tick();
    bus.key_valid_i = 1'b0;
  endtask

  task automatic push(input logic [127:0] p);
    bit ok = 1'b0;
    bus.data_valid_i = 1'b1; bus.data_i = p;
    for (int i = 0; i < 1000 && !ok; i++) begin @(negedge clk_i); ok = bus.data_ready_o; end
    check("data_accept_timeout", ok, 1);
    tick();
    bus.data_valid_i = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin @(negedge clk_i); ok = bus.cipher_valid_o; end
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk_i);
      ok = (exp_q.size() == 0) && !busy_o && !bus.cipher_valid_o;
    end
    check("drain_timeout", ok, 1);
    tick();
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] exp_ct;
    logic [15:0]  exp_cnt;
  } vec_t;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;

  initial begin : main
    vec_t tbl[5];
    logic [127:0] loaded, held, k2, p4, p5;
    bit have_key, ok;
    int s0, d0, ld0, cyc;

    tbl[0] = '{128'h0, 128'h0, GOLD,               16'd1};
    tbl[1] = '{128'h0, P1,     mock_enc(128'h0, P1), 16'd2};
    tbl[2] = '{K1,     P1,     mock_enc(K1, P1),     16'd3};
    tbl[3] = '{K1,     128'h0, mock_enc(K1, 128'h0), 16'd4};
    tbl[4] = '{K1,     ~P1,    mock_enc(K1, ~P1),    16'd5};

    do_reset("reset");

    // table: single blocks, key reloaded only when it changes
    have_key = 1'b0; loaded = '0;
    for (int i = 0; i < 5; i++) begin
      if (!have_key || tbl[i].key !== loaded) begin
        load_key(tbl[i].key);
        loaded = tbl[i].key; have_key = 1'b1;
      end
      bus.cipher_ready_i = 1'b1;
      push(tbl[i].pt);
      wait_valid(ok);
      check($sformatf("vec%0d_valid_timeout", i), ok, 1);
      check($sformatf("vec%0d_cipher", i), bus.cipher_o, tbl[i].exp_ct);
      tick();
      check($sformatf("vec%0d_blk_cnt", i), blk_cnt_o, tbl[i].exp_cnt);
      if (i == 0) begin
        check("t1_key_ld_pulses", n_ld, 1);
        check("t1_start_pulses", n_start, 1);
      end
    end
    drain();

    // back-to-back blocks under the cached key
    chk_dr = 1'b1;
    ld0 = n_ld; d0 = n_deliv;
    for (int i = 0; i < 4; i++) push(rnd128());
    drain();
    check("t2_no_key_reload", n_ld, ld0);
    check("t2_delivered", n_deliv - d0, 4);

    // sink stalls with six blocks offered
    bus.cipher_ready_i = 1'b0;
    s0 = n_start; d0 = n_deliv;
    fork
      for (int i = 0; i < 6; i++) push(rnd128());
      begin
        bit vok;
        wait_valid(vok);
        check("t3_first_valid", vok, 1);
        held = bus.cipher_o;
        repeat (100) tick();
        stray = 1'b1; tick(); stray = 1'b0;   // done pulse outside ENC_WAIT
        repeat (100) tick();
        @(negedge clk_i);
        check("t3_cipher_held", bus.cipher_o, held);
        check("t3_valid_held", bus.cipher_valid_o, 1);
        check("t3_one_started", n_start - s0, 1);
        check("t3_none_delivered", n_deliv - d0, 0);
        check("t3_data_ready_low", bus.data_ready_o, 0);
        check("t3_busy", busy_o, 1);
        tick();
        bus.cipher_ready_i = 1'b1;
      end
    join
    drain();
    check("t3_all_delivered", n_deliv - d0, 6);
    chk_dr = 1'b0;

    // key and data offered together: key wins
    k2 = rnd128(); p4 = rnd128();
    bus.key_i = k2; bus.key_valid_i = 1'b1;
    bus.data_i = p4; bus.data_valid_i = 1'b1;
    @(negedge clk_i);
    check("t4_key_ready", bus.key_ready_o, 1);
    check("t4_data_refused", bus.data_ready_o, 0);
    tick();
    bus.key_valid_i = 1'b0;
    cyc = 0; ok = 1'b0;
    for (int i = 1; i < 100 && !ok; i++) begin
      @(negedge clk_i);
      ok = bus.data_ready_o; cyc = i;
    end
    check("t4_data_ready_latency", cyc, KEY_LAT + 3);
    tick();
    bus.data_valid_i = 1'b0;
    drain();
    check("t4_cipher_new_key", last_ct, mock_enc(k2, p4));

    // reset while a block is in the core
    p5 = rnd128();
    push(p5);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin @(negedge clk_i); ok = core_start_o; end
    check("t5_start_seen", ok, 1);
    tick();
    #2;
    do_reset("t5_reset");
    bus.data_i = p5; bus.data_valid_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      check("t5_data_ready_no_key", bus.data_ready_o, 0);
    end
    check("t5_no_stale_cipher", bus.cipher_valid_o, 0);
    tick();
    bus.data_valid_i = 1'b0;
    bus.cipher_ready_i = 1'b1;
    load_key(K1);
    push(p5);
    drain();
    check("t5_cipher_after_reset", last_ct, mock_enc(K1, p5));
    check("t5_blk_cnt", blk_cnt_o, 1);

    // counter wrap
    force dut.blk_cnt = 16'hFFFF;
    tick();
    release dut.blk_cnt;
    cnt_mdl = 16'hFFFF;
    tick();
    check("t6_preload", blk_cnt_o, 16'hFFFF);
    push(rnd128());
    drain();
    check("t6_wrap", blk_cnt_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
